wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Parameters
REQ-001 WIDTH, 32, data width of register-file write data.
REQ-002 DEPTH, 4, load-response buffer entries; power of two, >= 2.

Interface
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU result offered this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  WIDTH  ALU result.
REQ-008 alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
REQ-009 ld_valid  input  1  load response arrives; no backpressure, one-cycle pulse per response.
REQ-010 ld_rd  input  5  load destination register.
REQ-011 ld_data  input  WIDTH  load data.
REQ-012 q_addr  input  5  hazard query register index.
REQ-013 q_hit  output  1  combinational: some buffered load targets q_addr (q_addr != 0).
REQ-014 we3  output  1  register-file write enable, registered.
REQ-015 a3  output  5  register-file write address, registered.
REQ-016 wd3  output  WIDTH  register-file write data, registered.
REQ-017 pend_cnt  output  $clog2(DEPTH)+1  buffered load count, registered.
REQ-018 ld_ovf  output  1  sticky: a load response was dropped.

Function
REQ-019 Block drives the write port of the 32-entry register file; at most one write per cycle.
REQ-020 Load responses with ld_rd != 0 push into a DEPTH-entry FIFO; ld_rd == 0 responses are discarded without error.
REQ-021 alu_ready = (pend_cnt != DEPTH), combinational from registered count.
REQ-022 Per-cycle selection, priority order: (a) FIFO full -> pop FIFO head; (b) alu_valid && alu_ready -> ALU; (c) FIFO non-empty -> pop head; (d) idle.
REQ-023 Selected source appears on we3/a3/wd3 on the next rising edge (1-cycle latency); idle cycle -> we3 = 0, a3/wd3 hold.
REQ-024 Loads always traverse the FIFO: minimum load latency ld_valid -> we3 is 2 cycles.
REQ-025 Selected ALU result with alu_rd == 0: accepted (consumes the slot), we3 = 0 next cycle.
REQ-026 Simultaneous push and pop in one cycle: both occur, pend_cnt unchanged, FIFO order preserved.
REQ-027 Push when full with no pop this cycle: impossible by REQ-022 (full forces pop); push when full with pop proceeds normally.
REQ-028 Drop condition: push attempted while count == DEPTH and pop blocked is unreachable; ld_ovf still implemented and set if internal count would exceed DEPTH (defensive), cleared only by rst.
REQ-029 FIFO pointers wrap modulo DEPTH; pend_cnt ranges 0..DEPTH.
REQ-030 q_hit compares q_addr against ld_rd of every valid FIFO entry; excludes the entry being popped this cycle; q_addr == 0 -> q_hit = 0.
REQ-031 FIFO order is strict arrival order; ALU results are never reordered with each other.

Reset
REQ-032 rst at a clock edge: we3 = 0, a3 = 0, wd3 = 0, pend_cnt = 0, ld_ovf = 0, FIFO pointers = 0, all entries invalid.
REQ-033 rst asserted mid-operation discards all buffered loads; inputs sampled in the reset cycle are ignored; alu_ready = 1 in the first cycle after reset.

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle 0 -> cycle 1 we3=1, a3=5, wd3=0x1234.
REQ-035 Load while ALU idle: ld_valid, ld_rd=7, ld_data=0xCAFE at cycle 0 -> pend_cnt=1 at cycle 1, we3=1/a3=7/wd3=0xCAFE at cycle 2, pend_cnt=0.
REQ-036 Fill: 4 consecutive loads (rd 1..4) with continuous alu_valid -> ALU wins until pend_cnt=4, then alu_ready=0, FIFO head rd=1 written next, alu_ready returns 1 when count drops to 3; loads write in order 1,2,3,4.
REQ-037 x0 handling: alu_rd=0 -> we3=0 next cycle; ld_rd=0 -> pend_cnt stays 0, ld_ovf=0.
REQ-038 Hazard query: load rd=9 buffered behind ALU traffic, q_addr=9 -> q_hit=1 until the cycle it is popped; q_addr=0 -> q_hit=0.
REQ-039 Reset mid-stream: 3 loads buffered, rst pulsed one cycle -> pend_cnt=0, we3=0, no buffered load ever written afterwards.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Register-file write-port arbitration bus: ALU results, load responses,
// hazard query and the registered write port.
interface wb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             alu_ready;
    logic             ld_valid;
    logic [4:0]       ld_rd;
    logic [WIDTH-1:0] ld_data;
    logic [4:0]       q_addr;
    logic             q_hit;
    logic             we3;
    logic [4:0]       a3;
    logic [WIDTH-1:0] wd3;
    logic [CW-1:0]    pend_cnt;
    logic             ld_ovf;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_addr,
        input  alu_ready, q_hit, we3, a3, wd3, pend_cnt, ld_ovf
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_addr,
        output alu_ready, q_hit, we3, a3, wd3, pend_cnt, ld_ovf
    );
endinterface

// File: rtl/wb_arbiter.sv
// Arbitrates ALU results and buffered load responses onto the single
// register-file write port; loads always pass through a small FIFO.
module wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [4:0]       rd_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             we3_q, we3_d;
    logic [4:0]       a3_q, a3_d;
    logic [WIDTH-1:0] wd3_q, wd3_d;

    logic full, empty, push, pop, take_alu, drop, do_push, hit;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        push     = bus.ld_valid && (bus.ld_rd != 5'd0);
        pop      = 1'b0;
        take_alu = 1'b0;
        // A full FIFO must drain first so an arriving load always has a slot.
        if (full)               pop      = 1'b1;
        else if (bus.alu_valid) take_alu = 1'b1;
        else if (!empty)        pop      = 1'b1;

        drop    = push && full && !pop;
        do_push = push && !drop;

        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (pop) begin
            we3_d = 1'b1;
            a3_d  = rd_mem[rd_ptr_q];
            wd3_d = data_mem[rd_ptr_q];
        end else if (take_alu && (bus.alu_rd != 5'd0)) begin
            we3_d = 1'b1;
            a3_d  = bus.alu_rd;
            wd3_d = bus.alu_data;
        end

        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(pop);
        ovf_d   = ovf_q | drop;
    end

    // The entry leaving this cycle is already on its way to the register file.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (rd_mem[i] == bus.q_addr) && !(pop && (PW'(i) == rd_ptr_q)))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            we3_q    <= 1'b0;
            a3_q     <= 5'd0;
            wd3_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            rd_mem[wr_ptr_q]   <= bus.ld_rd;
            data_mem[wr_ptr_q] <= bus.ld_data;
        end
    end

    assign bus.alu_ready = !full;
    assign bus.q_hit     = hit && (bus.q_addr != 5'd0);
    assign bus.we3       = we3_q;
    assign bus.a3        = a3_q;
    assign bus.wd3       = wd3_q;
    assign bus.pend_cnt  = count_q;
    assign bus.ld_ovf    = ovf_q;
endmodule
